line_feeder: RTL

- Serial-to-parallel line assembler that feeds the correlator Top from a pixel stream.
- Accepts one image pixel plus NUM_TEMPLATES template pixels per beat over valid/ready, and assembles LINE_SIZE beats into a line.
- Presents full lines on I_out_line/T_out_line, matching Top's I_in_line/T_in_line layout.
- Generates the accumulator-clear strobe at each window start and a last-line marker every NUM_OF_LINES lines.

---
 rtl/line_feeder_pkg.sv | 21 ++
 rtl/line_assembler.sv | 90 +++++++++
 rtl/line_feeder.sv | 113 +++++++++++
 3 files changed

// File: rtl/line_feeder_pkg.sv
// Shared types and default geometry for the line feeder.
// Build with LINE_FEEDER_FLUSH_EN defined to add the partial-line flush input.
package line_feeder_pkg;

    localparam int unsigned PIXEL_SIZE_DEF    = 8;
    localparam int unsigned LINE_SIZE_DEF     = 8;
    localparam int unsigned NUM_TEMPLATES_DEF = 2;
    localparam int unsigned NUM_OF_LINES_DEF  = 8;

    // Counter width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned LINE_IDX_W = idx_width(NUM_OF_LINES_DEF);

    typedef logic [PIXEL_SIZE_DEF-1:0] pixel_t;
    typedef pixel_t [LINE_SIZE_DEF-1:0] line_t;
    typedef pixel_t [LINE_SIZE_DEF-1:0][NUM_TEMPLATES_DEF-1:0] tpl_line_t;

endpackage

// File: rtl/line_assembler.sv
// Collects accepted beats into a one-line assembly buffer and flags when it is full.
// LINE_FEEDER_FLUSH_EN adds a flush input that zero-fills and closes a partial line.
module line_assembler import line_feeder_pkg::*; #(
    parameter int unsigned PIXEL_SIZE    = PIXEL_SIZE_DEF,
    parameter int unsigned LINE_SIZE     = LINE_SIZE_DEF,
    parameter int unsigned NUM_TEMPLATES = NUM_TEMPLATES_DEF
) (
    input  logic                                              CLK,
    input  logic                                              reset,
`ifdef LINE_FEEDER_FLUSH_EN
    input  logic                                              flush,
`endif
    input  logic [PIXEL_SIZE-1:0]                             pix_in,
    input  logic [NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0]          tpl_in,
    input  logic                                              pix_valid,
    input  logic                                              hold_free,
    output logic                                              pix_ready,
    output logic                                              asm_full,
    output logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]              asm_img,
    output logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0] asm_tpl
);

    localparam int unsigned CntW = idx_width(LINE_SIZE);
    localparam logic [CntW-1:0] LastBeat = CntW'(LINE_SIZE - 1);

    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            asm_full_q, asm_full_d;
    logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                   img_q, img_d;
    logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0] tpl_q, tpl_d;
    logic            accept, move, flush_now;

`ifdef LINE_FEEDER_FLUSH_EN
    assign flush_now = flush && (beat_cnt_q != '0) && !asm_full_q;
`else
    assign flush_now = 1'b0;
`endif

    // The buffered line leaves on the same edge the hold stage can take it.
    assign move      = asm_full_q && hold_free;
    assign pix_ready = (!asm_full_q || hold_free) && !flush_now;
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        asm_full_d = asm_full_q;
        img_d      = img_q;
        tpl_d      = tpl_q;
        if (move) begin
            asm_full_d = 1'b0;
        end
        if (flush_now) begin
            for (int i = 0; i < LINE_SIZE; i++) begin
                if (CntW'(i) >= beat_cnt_q) begin
                    img_d[i] = '0;
                    tpl_d[i] = '0;
                end
            end
            asm_full_d = 1'b1;
            beat_cnt_d = '0;
        end else if (accept) begin
            img_d[beat_cnt_q] = pix_in;
            tpl_d[beat_cnt_q] = tpl_in;
            if (beat_cnt_q == LastBeat) begin
                asm_full_d = 1'b1;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            beat_cnt_q <= '0;
            asm_full_q <= 1'b0;
            img_q      <= '0;
            tpl_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            asm_full_q <= asm_full_d;
            img_q      <= img_d;
            tpl_q      <= tpl_d;
        end
    end

    assign asm_full = asm_full_q;
    assign asm_img  = img_q;
    assign asm_tpl  = tpl_q;

endmodule

// File: rtl/line_feeder.sv
// Pixel-stream to line assembler feeding the correlator, with window markers.
// LINE_FEEDER_FLUSH_EN adds a flush input that closes a partial line with zeros.
module line_feeder import line_feeder_pkg::*; #(
    parameter int unsigned PIXEL_SIZE    = PIXEL_SIZE_DEF,
    parameter int unsigned LINE_SIZE     = LINE_SIZE_DEF,
    parameter int unsigned NUM_TEMPLATES = NUM_TEMPLATES_DEF,
    parameter int unsigned NUM_OF_LINES  = NUM_OF_LINES_DEF
) (
    input  logic                                              CLK,
    input  logic                                              reset,
`ifdef LINE_FEEDER_FLUSH_EN
    input  logic                                              flush,
`endif
    input  logic [PIXEL_SIZE-1:0]                             pix_in,
    input  logic [NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0]          tpl_in,
    input  logic                                              pix_valid,
    output logic                                              pix_ready,
    output logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]              I_out_line,
    output logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0] T_out_line,
    output logic                                              line_valid,
    input  logic                                              line_ready,
    output logic                                              acc_clr,
    output logic                                              win_last,
    output logic [idx_width(NUM_OF_LINES)-1:0]                line_idx
);

    localparam int unsigned IdxW = idx_width(NUM_OF_LINES);
    localparam logic [IdxW-1:0] LastWin = IdxW'(NUM_OF_LINES - 1);

    logic hold_free, asm_full, move;
    logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                   asm_img, img_q, img_d;
    logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0] asm_tpl, tpl_q, tpl_d;
    logic            line_valid_q, line_valid_d;
    logic            acc_clr_q, acc_clr_d;
    logic            win_last_q, win_last_d;
    logic [IdxW-1:0] line_idx_q, line_idx_d;
    logic [IdxW-1:0] win_cnt_q, win_cnt_d;

    assign hold_free = !line_valid_q || line_ready;
    assign move      = asm_full && hold_free;

    line_assembler #(
        .PIXEL_SIZE    (PIXEL_SIZE),
        .LINE_SIZE     (LINE_SIZE),
        .NUM_TEMPLATES (NUM_TEMPLATES)
    ) u_asm (
        .CLK       (CLK),
        .reset     (reset),
`ifdef LINE_FEEDER_FLUSH_EN
        .flush     (flush),
`endif
        .pix_in    (pix_in),
        .tpl_in    (tpl_in),
        .pix_valid (pix_valid),
        .hold_free (hold_free),
        .pix_ready (pix_ready),
        .asm_full  (asm_full),
        .asm_img   (asm_img),
        .asm_tpl   (asm_tpl)
    );

    always_comb begin
        img_d        = img_q;
        tpl_d        = tpl_q;
        line_valid_d = line_valid_q;
        acc_clr_d    = acc_clr_q;
        win_last_d   = win_last_q;
        line_idx_d   = line_idx_q;
        win_cnt_d    = win_cnt_q;
        if (move) begin
            img_d        = asm_img;
            tpl_d        = asm_tpl;
            line_valid_d = 1'b1;
            line_idx_d   = win_cnt_q;
            acc_clr_d    = (win_cnt_q == '0);
            win_last_d   = (win_cnt_q == LastWin);
            win_cnt_d    = (win_cnt_q == LastWin) ? '0 : win_cnt_q + 1'b1;
        end else if (hold_free) begin
            // Data is left in place; only the strobes retire with line_valid.
            line_valid_d = 1'b0;
            acc_clr_d    = 1'b0;
            win_last_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            img_q        <= '0;
            tpl_q        <= '0;
            line_valid_q <= 1'b0;
            acc_clr_q    <= 1'b0;
            win_last_q   <= 1'b0;
            line_idx_q   <= '0;
            win_cnt_q    <= '0;
        end else begin
            img_q        <= img_d;
            tpl_q        <= tpl_d;
            line_valid_q <= line_valid_d;
            acc_clr_q    <= acc_clr_d;
            win_last_q   <= win_last_d;
            line_idx_q   <= line_idx_d;
            win_cnt_q    <= win_cnt_d;
        end
    end

    assign I_out_line = img_q;
    assign T_out_line = tpl_q;
    assign line_valid = line_valid_q;
    assign acc_clr    = acc_clr_q;
    assign win_last   = win_last_q;
    assign line_idx   = line_idx_q;

endmodule
